// File: rtl/frame_rx_monitor.sv
// Serial frame receiver: hunts for the SFD, shifts in a 12-bit body, filters on
// destination/source address and queues accepted frames in a 4-deep FIFO.
module frame_rx_monitor #(
  parameter logic [3:0] MAC_ADDRESS = 4'hA,
  parameter bit         PROMISC     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_bit,
  output logic [15:0] rx_frame,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_pulse,
  output logic [7:0]  accept_count,
  output logic [7:0]  drop_count,
  output logic        overflow,
  output logic        rx_busy
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BODY_W  = 12;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned OCC_W   = 3;
  localparam int unsigned CNT_W   = 8;
  localparam logic [3:0]  SFD     = 4'b0101;
  localparam logic [3:0]  BCAST   = 4'hF;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_hist;
  logic [3:0]           r_bit_cnt;
  logic [BODY_W-1:0]    r_body;
  logic [FRAME_W-1:0]   r_mem [DEPTH];
  logic [FRAME_W-1:0]   w_mem_next [DEPTH];
  logic [OCC_W-1:0]     r_count;
  logic [OCC_W-1:0]     w_count_next;
  logic [OCC_W-1:0]     w_wr_idx;
  logic                 r_valid;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_accept;
  logic [CNT_W-1:0]     r_drop;
  logic                 r_overflow;

  logic [3:0]           w_hist_shift;
  logic [3:0]           w_dst;
  logic [3:0]           w_src;
  logic                 w_match;
  logic                 w_check;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_lost;
  logic                 w_reject;

  assign w_hist_shift = {r_hist[2:0], rx_bit};
  assign w_dst        = r_body[11:8];
  assign w_src        = r_body[7:4];
  assign w_match      = (PROMISC || (w_dst == MAC_ADDRESS) || (w_dst == BCAST))
                        && (w_src != MAC_ADDRESS);
  assign w_check      = (r_state == CHECK);
  assign w_full       = (r_count == OCC_W'(DEPTH));
  assign w_pop        = (r_count != '0) && rx_ready;
  assign w_push       = w_check && w_match && (!w_full || w_pop);
  assign w_lost       = w_check && w_match && w_full && !w_pop;
  assign w_reject     = w_check && !w_match;
  assign w_count_next = r_count - OCC_W'(w_pop) + OCC_W'(w_push);
  assign w_wr_idx     = r_count - OCC_W'(w_pop);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_state_next;
  end

  // Next-state logic; a started frame always runs to CHECK
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HUNT:    if (w_hist_shift == SFD) w_state_next = SHIFT;
      SHIFT:   if (r_bit_cnt == 4'(BODY_W - 1)) w_state_next = CHECK;
      CHECK:   w_state_next = HUNT;
      default: w_state_next = HUNT;
    endcase
  end

  // SFD history, bit counter and body shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist    <= '0;
      r_bit_cnt <= '0;
      r_body    <= '0;
    end else begin
      case (r_state)
        HUNT: begin
          r_hist    <= w_hist_shift;
          r_bit_cnt <= '0;
        end
        SHIFT: begin
          r_body    <= {r_body[BODY_W-2:0], rx_bit};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        default: begin
          r_hist    <= '0;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  // Shift-down FIFO: entry 0 is the registered head
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) w_mem_next[i] = r_mem[i];
    if (w_pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) w_mem_next[i] = r_mem[i+1];
    end
    if (w_push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_wr_idx == OCC_W'(i)) w_mem_next[i] = {SFD, r_body};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= w_mem_next[i];
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
    end
  end

  // Saturating statistics and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accept   <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_push && (r_accept != '1))  r_accept <= r_accept + CNT_W'(1);
      if (w_reject && (r_drop != '1))  r_drop   <= r_drop + CNT_W'(1);
      if (w_lost)                      r_overflow <= 1'b1;
      r_busy <= (w_state_next != HUNT);
    end
  end

  assign rx_frame     = r_mem[0];
  assign rx_valid     = r_valid;
  assign frame_pulse  = w_push;
  assign accept_count = r_accept;
  assign drop_count   = r_drop;
  assign overflow     = r_overflow;
  assign rx_busy      = r_busy;

endmodule

// File: tb/tb_frame_rx_monitor.sv
// Scoreboard bench for frame_rx_monitor: expected frames are queued when sent
// and compared whenever a pop happens; counters are tracked by a small model.
module tb_frame_rx_monitor;

  logic        clk;
  logic        rst;
  logic        rx_bit;
  logic [15:0] rx_frame;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_pulse;
  logic [7:0]  accept_count;
  logic [7:0]  drop_count;
  logic        overflow;
  logic        rx_busy;

  int          errors;
  int          checks;
  logic [15:0] sb_q [$];
  int          exp_acc;
  int          exp_drop;
  logic        exp_ovf;

  frame_rx_monitor #(.MAC_ADDRESS(4'hA), .PROMISC(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_bit      (rx_bit),
    .rx_frame    (rx_frame),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_pulse (frame_pulse),
    .accept_count(accept_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .rx_busy     (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called right after rx_ready is driven for the coming edge
  task automatic sb_pop();
    if (rx_ready) begin
      checks++;
      if (sb_q.size() > 0) begin
        if (rx_valid !== 1'b1 || rx_frame !== sb_q[0]) begin
          errors++;
          $display("FAIL sb_pop: got valid=%b frame=%h, expected valid=1 frame=%h",
                   rx_valid, rx_frame, sb_q[0]);
        end
        void'(sb_q.pop_front());
      end else if (rx_valid !== 1'b0) begin
        errors++;
        $display("FAIL sb_empty: got valid=%b, expected 0", rx_valid);
      end
    end
  endtask

  task automatic idle_step(input logic rdy);
    @(negedge clk);
    rx_bit   = 1'b0;
    rx_ready = rdy;
    sb_pop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_bit   = 1'b0;
    rx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    exp_acc  = 0;
    exp_drop = 0;
    exp_ovf  = 1'b0;
  endtask

  // Serialises one frame MSB first, then checks the CHECK-cycle behaviour
  task automatic send_frame(input logic [15:0] f, input logic rdy, input logic rdy_chk);
    logic acc;
    logic exp_pulse;
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      rx_bit   = f[i];
      rx_ready = rdy;
      sb_pop();
    end
    @(negedge clk);
    rx_bit   = 1'b0;
    rx_ready = rdy_chk;
    sb_pop();
    #1;
    acc       = ((f[11:8] == 4'hA) || (f[11:8] == 4'hF)) && (f[7:4] != 4'hA);
    exp_pulse = acc && (sb_q.size() < 4);
    checks++;
    if (frame_pulse !== exp_pulse) begin
      errors++;
      $display("FAIL frame_pulse %h: got %b, expected %b", f, frame_pulse, exp_pulse);
    end
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL rx_busy_check %h: got %b, expected 1", f, rx_busy);
    end
    if (acc) begin
      if (sb_q.size() < 4) begin
        sb_q.push_back(f);
        if (exp_acc < 255) exp_acc++;
      end else begin
        exp_ovf = 1'b1;
      end
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_bit = 1'b0; rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_frame, rx_valid, frame_pulse, accept_count, drop_count, overflow, rx_busy} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state: got frame=%h valid=%b pulse=%b acc=%0d drop=%0d ovf=%b busy=%b, expected all 0",
               rx_frame, rx_valid, frame_pulse, accept_count, drop_count, overflow, rx_busy);
    end
    rst = 1'b0;
    sb_q.delete(); exp_acc = 0; exp_drop = 0; exp_ovf = 1'b0;
  endtask

  task automatic test_basic();
    idle_step(1'b0);
    idle_step(1'b0);
    send_frame(16'h5AB3, 1'b0, 1'b0);
    idle_step(1'b0);
    checks++;
    if (rx_valid !== 1'b1 || rx_frame !== 16'h5AB3) begin
      errors++;
      $display("FAIL basic_head: got valid=%b frame=%h, expected 1 5ab3", rx_valid, rx_frame);
    end
    checks++;
    if (accept_count !== 8'd1) begin
      errors++;
      $display("FAIL basic_acc: got %0d, expected 1", accept_count);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got %b, expected 0", rx_busy);
    end
    idle_step(1'b1);
    idle_step(1'b0);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got valid=%b, expected 0", rx_valid);
    end
  endtask

  task automatic test_filter();
    do_reset();
    send_frame(16'h5CB3, 1'b0, 1'b0);
    send_frame(16'h5FB3, 1'b0, 1'b0);
    send_frame(16'h5AA3, 1'b0, 1'b0);
    idle_step(1'b0);
    checks++;
    if (drop_count !== 8'(exp_drop) || exp_drop != 2) begin
      errors++;
      $display("FAIL filter_drop: got %0d, expected 2", drop_count);
    end
    checks++;
    if (accept_count !== 8'(exp_acc)) begin
      errors++;
      $display("FAIL filter_acc: got %0d, expected %0d", accept_count, exp_acc);
    end
    idle_step(1'b1);
    idle_step(1'b1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 5; k++) send_frame(16'h5AB0 + 16'(k), 1'b0, 1'b0);
    idle_step(1'b0);
    checks++;
    if (accept_count !== 8'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state: got acc=%0d ovf=%b, expected acc=4 ovf=1", accept_count, overflow);
    end
    for (int k = 0; k < 4; k++) begin
      idle_step(1'b1);
      idle_step(1'b0);
    end
    checks++;
    if (rx_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: got valid=%b ovf=%b, expected valid=0 ovf=1", rx_valid, overflow);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int k = 0; k < 4; k++) send_frame(16'h5AB1 + 16'(k), 1'b0, 1'b0);
    send_frame(16'h5AB5, 1'b0, 1'b1);
    idle_step(1'b0);
    checks++;
    if (overflow !== 1'b0 || accept_count !== 8'd5 || sb_q.size() != 4) begin
      errors++;
      $display("FAIL simul_push_pop: got ovf=%b acc=%0d, expected ovf=0 acc=5", overflow, accept_count);
    end
    repeat (5) idle_step(1'b1);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_drain: got valid=%b, expected 0", rx_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] f;
    do_reset();
    f = 16'h5AB3;
    for (int i = 15; i >= 4; i--) begin
      @(negedge clk);
      rx_bit = f[i];
    end
    @(negedge clk);
    rst = 1'b1;
    rx_bit = 1'b1;
    #1;
    checks++;
    if (rx_busy !== 1'b0 || accept_count !== 8'd0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: got busy=%b acc=%0d valid=%b, expected 0 0 0", rx_busy, accept_count, rx_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    rx_bit = 1'b0;
    send_frame(16'h5AB7, 1'b0, 1'b0);
    idle_step(1'b0);
    checks++;
    if (accept_count !== 8'd1 || drop_count !== 8'd0 || rx_frame !== 16'h5AB7) begin
      errors++;
      $display("FAIL midrst_resume: got acc=%0d drop=%0d frame=%h, expected 1 0 5ab7",
               accept_count, drop_count, rx_frame);
    end
    idle_step(1'b1);
    idle_step(1'b0);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drain: got valid=%b, expected 0", rx_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 256; k++) send_frame({12'h5FB, 4'(k)}, 1'b1, 1'b1);
    idle_step(1'b1);
    idle_step(1'b0);
    checks++;
    if (accept_count !== 8'hFF || exp_acc != 255) begin
      errors++;
      $display("FAIL sat_accept: got %0d, expected 255", accept_count);
    end
    for (int k = 0; k < 256; k++) send_frame(16'h5CB3, 1'b0, 1'b0);
    idle_step(1'b0);
    checks++;
    if (drop_count !== 8'hFF || accept_count !== 8'hFF) begin
      errors++;
      $display("FAIL sat_drop: got drop=%0d acc=%0d, expected 255 255", drop_count, accept_count);
    end
    checks++;
    if (overflow !== exp_ovf || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_final: got ovf=%b valid=%b, expected %b 0", overflow, rx_valid, exp_ovf);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_full_simul();
    test_mid_reset();
    test_saturation();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d queued frames, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_rx_monitor.md
FRAME_RX_MONITOR -- requirements
Module: frame_rx_monitor

Interface
REQ-001 SHALL have parameter MAC_ADDRESS, default 4'hA, own station address used for filtering.
REQ-002 SHALL have parameter PROMISC, default 0; when 1, the destination filter is bypassed.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx_bit, input, 1, serial line from the switch port, one bit per clk, MSB first, idle 0.
REQ-006 SHALL have port rx_frame, output, 16, the full frame {SFD, DST, SRC, PAYLOAD} at the FIFO head.
REQ-007 SHALL have port rx_valid, output, 1, high while the FIFO is non-empty.
REQ-008 SHALL have port rx_ready, input, 1, consumer pop request; a pop occurs when rx_valid && rx_ready.
REQ-009 SHALL have port frame_pulse, output, 1, one-clk pulse per accepted frame.
REQ-010 SHALL have port accept_count, output, 8, count of accepted frames.
REQ-011 SHALL have port drop_count, output, 8, count of frames rejected by the filter.
REQ-012 SHALL have port overflow, output, 1, sticky flag for a frame lost to a full FIFO.
REQ-013 SHALL have port rx_busy, output, 1, high in the SHIFT and CHECK states.

Function
REQ-014 Frame format SHALL be 16 bits: [15:12] SFD = 4'b0101, [11:8] DST, [7:4] SRC, [3:0] PAYLOAD.
REQ-015 The FSM SHALL have states HUNT, SHIFT, CHECK.
REQ-016 HUNT SHALL shift rx_bit into a 4-bit history; when {history[2:0], rx_bit} == 4'b0101, the block SHALL go to SHIFT with bit counter 0.
REQ-017 SHIFT SHALL capture exactly 12 bits (DST, SRC, PAYLOAD), one per clk, then go to CHECK.
REQ-018 CHECK SHALL last one clk, evaluate the filter and return to HUNT with the 4-bit history cleared to 0.
  - Clearing the history means frame bits never form a false SFD.
REQ-019 Filter SHALL accept when (DST == MAC_ADDRESS or DST == 4'hF or PROMISC == 1) and SRC != MAC_ADDRESS; otherwise it SHALL reject.
REQ-020 On accept in CHECK: frame_pulse = 1 in that clk, and the frame is pushed to the FIFO.
  - Pushed frame is visible on rx_frame with rx_valid = 1 from the next clk (latency 1 after CHECK, 18 clks after the first SFD bit).
REQ-021 On reject: drop_count SHALL increment, with no push and no frame_pulse.
REQ-022 The FIFO SHALL be 4 entries deep, first-in first-out, with rx_frame registered at the head.
REQ-023 Push and pop in the same clk SHALL both take effect, including when the FIFO is full.
REQ-024 Push into a full FIFO with no pop SHALL:
  - discard the new frame;
  - set overflow;
  - not increment accept_count;
  - suppress frame_pulse.
REQ-025 A pop on an empty FIFO SHALL be ignored.
REQ-026 accept_count and drop_count SHALL saturate at 8'hFF, with no wrap-around.
REQ-027 overflow SHALL clear only on rst.
REQ-028 rx_bit activity during SHIFT/CHECK SHALL NOT restart SFD detection; a frame is always fully consumed once started.

Reset
REQ-029 On rst, SHALL force state = HUNT, history = 0, bit counter = 0, FIFO empty, rx_frame = 16'h0000, rx_valid = 0, frame_pulse = 0, accept_count = 0, drop_count = 0, overflow = 0, rx_busy = 0.
REQ-030 rst asserted mid-frame SHALL abort the frame with no push and no counter change; after release, the block SHALL resume hunting on the next clk.

Verification
REQ-031 Drive 0101_1010_1011_0011 after idle, rx_ready = 0 -> frame_pulse 1 clk, then rx_frame = 16'h5AB3, rx_valid = 1, accept_count = 1.
REQ-032 Drive 16'h5CB3 (DST C) with MAC_ADDRESS = A -> no push, drop_count = 1. Drive 16'h5FB3 -> accepted (broadcast). Drive 16'h5AA3 -> dropped (own SRC).
REQ-033 Send five frames 16'h5AB0..16'h5AB4 with rx_ready = 0 -> FIFO holds 5AB0..5AB3, overflow = 1, accept_count = 4. Then pop four times -> 5AB0, 5AB1, 5AB2, 5AB3 in order, rx_valid = 0.
REQ-034 With the FIFO full, hold rx_ready = 1 during the CHECK clk of a fifth frame -> pop and push are simultaneous, no overflow, occupancy stays 4.
REQ-035 Assert rst after 8 SHIFT bits of 16'h5AB3, release, then send 16'h5AB7 -> only 5AB7 is received, accept_count = 1.
REQ-036 Send 256 accepted frames with continuous pops -> accept_count holds 8'hFF.
